// File: rtl/tlp_ctl_pkg.sv
// Shared TLP control definitions: packet-generator type codes, checker
// completion types, request arbiter state encodings and payload structs.
package tlp_ctl_pkg;

    localparam int unsigned TAG_W = 8;
    localparam int unsigned ST_W  = 3;

    // Packet generator TLP type codes
    localparam logic [2:0] TX_TYPE_MEMRD32 = 3'b000;
    localparam logic [2:0] TX_TYPE_MEMWR32 = 3'b001;
    localparam logic [2:0] TX_TYPE_MEMRD64 = 3'b010;
    localparam logic [2:0] TX_TYPE_MEMWR64 = 3'b011;

    // Checker completion types
    localparam logic RX_TYPE_CPL  = 1'b0;
    localparam logic RX_TYPE_CPLD = 1'b1;

    // Request arbiter states
    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_ISSUE    = 3'd1;
    localparam logic [ST_W-1:0] ST_TX_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_CPL_WAIT = 3'd3;
    localparam logic [ST_W-1:0] ST_RESP     = 3'd4;

    // Request captured at grant time
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } tlp_req_t;

    // Fields presented to the packet generator and checker
    typedef struct packed {
        logic [2:0]       tx_type;
        logic [TAG_W-1:0] tx_tag;
        logic [63:0]      tx_addr;
        logic [127:0]     tx_data;
        logic [10:0]      tx_length;
        logic             rx_type;
        logic [TAG_W-1:0] rx_tag;
        logic [31:0]      rx_data;
    } tlp_desc_t;

    // Saturating 16-bit increment
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational grant search starting at an internal
// pointer, with the pointer moving past the winner when the grant is taken.
//   user_clk, reset   : clock, synchronous active-high reset
//   req               : request vector, one bit per requester
//   advance           : grant consumed this cycle; move the pointer
//   grant_valid_c     : some request is set
//   grant_idx_c       : index of the selected requester
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               user_clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               grant_valid_c,
    output logic [IDX_W-1:0]   grant_idx_c
);

    logic [IDX_W-1:0] ptr;
    int unsigned      cand;

    // First set request at or after ptr, wrapping around
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand          = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!grant_valid_c && req[cand[IDX_W-1:0]]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves to the requester after the winner
    always_ff @(posedge user_clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && grant_valid_c) begin
            if (32'(grant_idx_c) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx_c + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/tlp_req_arbiter.sv
// Shares one packet-generator/checker pair between NUM_REQ requesters.
// One transaction in flight: grant, issue, wait tx_done, wait completion
// (reads), then a per-requester ok/fail pulse.
//   user_clk, reset, user_lnk_up, enable : clock, sync reset, link, go
//   req_valid/write/addr/data, req_ack   : requester side
//   rsp_ok, rsp_fail                     : per-requester verdict pulses
//   tx_*, tx_done                        : packet generator side
//   rx_*, rx_success, rx_fail            : completion checker side
//   busy, err_count                      : status
module tlp_req_arbiter
    import tlp_ctl_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned CPL_TIMEOUT = 1024,
    parameter int          TCQ         = 1
) (
    input  logic                  user_clk,
    input  logic                  reset,
    input  logic                  user_lnk_up,
    input  logic                  enable,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_ok,
    output logic [NUM_REQ-1:0]    rsp_fail,
    output logic [2:0]            tx_type,
    output logic [7:0]            tx_tag,
    output logic [63:0]           tx_addr,
    output logic [127:0]          tx_data,
    output logic [10:0]           tx_length,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  rx_type,
    output logic [7:0]            rx_tag,
    output logic [31:0]           rx_data,
    input  logic                  rx_success,
    input  logic                  rx_fail,
    output logic                  busy,
    output logic [15:0]           err_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(CPL_TIMEOUT);

    if (NUM_REQ < 2 || NUM_REQ > 4 || CPL_TIMEOUT < 2 || TCQ < 0) begin : g_bad_param
        $error("tlp_req_arbiter: parameter out of range");
    end

    logic [ST_W-1:0]    state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    tlp_req_t           cur, cur_nxt;
    tlp_desc_t          desc, desc_nxt;
    logic [TAG_W-1:0]   tag_cnt, tag_cnt_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               pass, pass_nxt;
    logic [NUM_REQ-1:0] req_ack_nxt, rsp_ok_nxt, rsp_fail_nxt;
    logic               tx_start_nxt;
    logic [15:0]        err_count_nxt;

    logic               grant_valid_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               rr_advance_c;
    logic [NUM_REQ-1:0] owner_oh_c;
    logic [NUM_REQ-1:0] grant_oh_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .user_clk      (user_clk),
        .reset         (reset),
        .req           (req_valid),
        .advance       (rr_advance_c),
        .grant_valid_c (grant_valid_c),
        .grant_idx_c   (grant_idx_c)
    );

    assign owner_oh_c = NUM_REQ'(1) << owner;
    assign grant_oh_c = NUM_REQ'(1) << grant_idx_c;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        cur_nxt       = cur;
        desc_nxt      = desc;
        tag_cnt_nxt   = tag_cnt;
        timer_nxt     = timer;
        pass_nxt      = pass;
        req_ack_nxt   = '0;
        rsp_ok_nxt    = '0;
        rsp_fail_nxt  = '0;
        tx_start_nxt  = 1'b0;
        err_count_nxt = err_count;
        rr_advance_c  = 1'b0;

        if (state != ST_IDLE && !user_lnk_up) begin
            // Link loss aborts whatever is in flight; tag and pointer persist
            state_nxt     = ST_IDLE;
            rsp_fail_nxt  = owner_oh_c;
            err_count_nxt = sat_inc16(err_count);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && user_lnk_up && grant_valid_c) begin
                        owner_nxt     = grant_idx_c;
                        cur_nxt.write = req_write[grant_idx_c];
                        cur_nxt.addr  = req_addr[{grant_idx_c, 5'd0} +: 32];
                        cur_nxt.data  = req_data[{grant_idx_c, 5'd0} +: 32];
                        req_ack_nxt   = grant_oh_c;
                        rr_advance_c  = 1'b1;
                        state_nxt     = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tag_cnt_nxt        = tag_cnt + 8'd1;
                    desc_nxt.tx_type   = cur.write ? TX_TYPE_MEMWR32 : TX_TYPE_MEMRD32;
                    desc_nxt.tx_tag    = tag_cnt + 8'd1;
                    desc_nxt.tx_addr   = {32'h0, cur.addr};
                    desc_nxt.tx_data   = {4{cur.data}};
                    desc_nxt.tx_length = 11'd1;
                    desc_nxt.rx_type   = cur.write ? RX_TYPE_CPL : RX_TYPE_CPLD;
                    desc_nxt.rx_tag    = tag_cnt + 8'd1;
                    desc_nxt.rx_data   = cur.data;
                    tx_start_nxt       = 1'b1;
                    state_nxt          = ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_done) begin
                        if (cur.write) begin
                            pass_nxt  = 1'b1;
                            state_nxt = ST_RESP;
                        end else begin
                            timer_nxt = '0;
                            state_nxt = ST_CPL_WAIT;
                        end
                    end
                end
                ST_CPL_WAIT: begin
                    // A checker verdict on the expiry cycle beats the timeout
                    if (rx_fail) begin
                        pass_nxt  = 1'b0;
                        state_nxt = ST_RESP;
                    end else if (rx_success) begin
                        pass_nxt  = 1'b1;
                        state_nxt = ST_RESP;
                    end else if (timer == TMR_W'(CPL_TIMEOUT - 1)) begin
                        pass_nxt  = 1'b0;
                        state_nxt = ST_RESP;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (pass) begin
                        rsp_ok_nxt = owner_oh_c;
                    end else begin
                        rsp_fail_nxt  = owner_oh_c;
                        err_count_nxt = sat_inc16(err_count);
                    end
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            cur       <= '0;
            desc      <= '0;
            tag_cnt   <= 8'hFF;
            timer     <= '0;
            pass      <= 1'b0;
            req_ack   <= '0;
            rsp_ok    <= '0;
            rsp_fail  <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            cur       <= cur_nxt;
            desc      <= desc_nxt;
            tag_cnt   <= tag_cnt_nxt;
            timer     <= timer_nxt;
            pass      <= pass_nxt;
            req_ack   <= req_ack_nxt;
            rsp_ok    <= rsp_ok_nxt;
            rsp_fail  <= rsp_fail_nxt;
            tx_start  <= tx_start_nxt;
            busy      <= (state_nxt != ST_IDLE);
            err_count <= err_count_nxt;
        end
    end

    assign tx_type   = desc.tx_type;
    assign tx_tag    = desc.tx_tag;
    assign tx_addr   = desc.tx_addr;
    assign tx_data   = desc.tx_data;
    assign tx_length = desc.tx_length;
    assign rx_type   = desc.rx_type;
    assign rx_tag    = desc.rx_tag;
    assign rx_data   = desc.rx_data;

endmodule

// File: tb/tb_tlp_req_arbiter.sv
// Directed bench for tlp_req_arbiter with a transaction scoreboard.
module tb_tlp_req_arbiter;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned CPL_TIMEOUT = 16;

    logic                  user_clk = 1'b0;
    logic                  reset;
    logic                  user_lnk_up;
    logic                  enable;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    rsp_ok;
    logic [NUM_REQ-1:0]    rsp_fail;
    logic [2:0]            tx_type;
    logic [7:0]            tx_tag;
    logic [63:0]           tx_addr;
    logic [127:0]          tx_data;
    logic [10:0]           tx_length;
    logic                  tx_start;
    logic                  tx_done;
    logic                  rx_type;
    logic [7:0]            rx_tag;
    logic [31:0]           rx_data;
    logic                  rx_success;
    logic                  rx_fail;
    logic                  busy;
    logic [15:0]           err_count;

    tlp_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CPL_TIMEOUT (CPL_TIMEOUT),
        .TCQ         (1)
    ) dut (
        .user_clk    (user_clk),
        .reset       (reset),
        .user_lnk_up (user_lnk_up),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .rsp_ok      (rsp_ok),
        .rsp_fail    (rsp_fail),
        .tx_type     (tx_type),
        .tx_tag      (tx_tag),
        .tx_addr     (tx_addr),
        .tx_data     (tx_data),
        .tx_length   (tx_length),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .rx_type     (rx_type),
        .rx_tag      (rx_tag),
        .rx_data     (rx_data),
        .rx_success  (rx_success),
        .rx_fail     (rx_fail),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        int          owner;
        bit          write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  tag;
    } txn_t;

    txn_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_tag;
    logic [15:0] exp_err;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Raise a request and record the transaction it should produce
    task automatic post_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.owner = i;
        t.write = w;
        t.addr  = a;
        t.data  = d;
        t.tag   = exp_tag;
        exp_tag = exp_tag + 8'd1;
        exp_q.push_back(t);
        req_valid[i]         = 1'b1;
        req_write[i]         = w;
        req_addr[32*i +: 32] = a;
        req_data[32*i +: 32] = d;
    endtask

    // Grant one cycle after the request, tx_start one cycle after that
    task automatic expect_issue(output txn_t t, input bit drop);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed 0 entries expected >0");
            $fatal(1, "scoreboard underflow");
        end
        t = exp_q.pop_front();
        tick();
        chk("req_ack",        128'(req_ack),  128'(oh(t.owner)));
        chk("busy_on_grant",  128'(busy),     128'(1'b1));
        chk("tx_start_early", 128'(tx_start), 128'(1'b0));
        if (drop) req_valid[t.owner] = 1'b0;
        tick();
        chk("tx_start",   128'(tx_start),  128'(1'b1));
        chk("ack_width",  128'(req_ack),   128'(0));
        chk("tx_type",    128'(tx_type),   128'(t.write ? 3'b001 : 3'b000));
        chk("tx_tag",     128'(tx_tag),    128'(t.tag));
        chk("tx_addr",    128'(tx_addr),   128'({32'h0, t.addr}));
        chk("tx_data",    tx_data,         {4{t.data}});
        chk("tx_length",  128'(tx_length), 128'(11'd1));
        chk("rx_type",    128'(rx_type),   128'(!t.write));
        chk("rx_tag",     128'(rx_tag),    128'(t.tag));
        chk("rx_data",    128'(rx_data),   128'(t.data));
    endtask

    // Write completes 2 cycles after tx_done; a stray rx_fail is ignored
    task automatic finish_write(input txn_t t);
        tx_done = 1'b1;
        rx_fail = 1'b1;
        tick();
        tx_done = 1'b0;
        rx_fail = 1'b0;
        chk("tx_start_width", 128'(tx_start),        128'(1'b0));
        chk("wr_rsp_early",   128'(rsp_ok | rsp_fail), 128'(0));
        tick();
        chk("wr_rsp_ok",   128'(rsp_ok),   128'(oh(t.owner)));
        chk("wr_rsp_fail", 128'(rsp_fail), 128'(0));
        chk("wr_busy",     128'(busy),     128'(1'b0));
    endtask

    // Read: checker pulses are sampled d cycles after tx_done is sampled
    task automatic finish_read(input txn_t t, input int d, input bit s, input bit f, input bit exp_ok);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int k = 1; k < d; k++) begin
            tick();
            chk("rd_quiet", 128'(rsp_ok | rsp_fail), 128'(0));
            chk("rd_busy",  128'(busy),              128'(1'b1));
        end
        rx_success = s;
        rx_fail    = f;
        tick();
        rx_success = 1'b0;
        rx_fail    = 1'b0;
        chk("rd_rsp_early", 128'(rsp_ok | rsp_fail), 128'(0));
        tick();
        if (!exp_ok) exp_err = exp_err + 16'd1;
        chk("rd_rsp_ok",   128'(rsp_ok),    128'(exp_ok ? oh(t.owner) : '0));
        chk("rd_rsp_fail", 128'(rsp_fail),  128'(exp_ok ? '0 : oh(t.owner)));
        chk("err_count",   128'(err_count), 128'(exp_err));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   128'(req_ack),   128'(0));
        chk({tag, "_ok"},    128'(rsp_ok),    128'(0));
        chk({tag, "_fail"},  128'(rsp_fail),  128'(0));
        chk({tag, "_type"},  128'(tx_type),   128'(0));
        chk({tag, "_tag"},   128'(tx_tag),    128'(0));
        chk({tag, "_addr"},  128'(tx_addr),   128'(0));
        chk({tag, "_data"},  tx_data,         128'(0));
        chk({tag, "_len"},   128'(tx_length), 128'(0));
        chk({tag, "_start"}, 128'(tx_start),  128'(0));
        chk({tag, "_rxt"},   128'(rx_type),   128'(0));
        chk({tag, "_rxtag"}, 128'(rx_tag),    128'(0));
        chk({tag, "_rxd"},   128'(rx_data),   128'(0));
        chk({tag, "_busy"},  128'(busy),      128'(0));
        chk({tag, "_err"},   128'(err_count), 128'(0));
    endtask

    initial begin
        txn_t t;
        reset       = 1'b1;
        user_lnk_up = 1'b1;
        enable      = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_data    = '0;
        tx_done     = 1'b0;
        rx_success  = 1'b0;
        rx_fail     = 1'b0;
        exp_tag     = 8'h00;
        exp_err     = 16'h0;

        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b0;

        // No grant while enable is low
        post_req(0, 1'b1, 32'h1000_0010, 32'hCAFE_F00D);
        repeat (3) begin
            tick();
            chk("ack_disabled", 128'(req_ack), 128'(0));
        end
        enable = 1'b1;
        expect_issue(t, 1'b1);
        finish_write(t);

        // Reads: success, mismatch, both pulses together
        post_req(1, 1'b0, 32'h2000_0040, 32'h1234_5678);
        expect_issue(t, 1'b1);
        finish_read(t, 5, 1'b1, 1'b0, 1'b1);
        post_req(2, 1'b0, 32'h2000_0044, 32'hDEAD_BEEF);
        expect_issue(t, 1'b1);
        finish_read(t, 3, 1'b0, 1'b1, 1'b0);
        post_req(2, 1'b0, 32'h2000_0048, 32'h0BAD_F00D);
        expect_issue(t, 1'b1);
        finish_read(t, 2, 1'b1, 1'b1, 1'b0);

        // Round robin with all three held
        post_req(0, 1'b1, 32'h3000_0000, 32'hA0A0_A0A0);
        post_req(1, 1'b1, 32'h3000_0004, 32'hB1B1_B1B1);
        post_req(2, 1'b1, 32'h3000_0008, 32'hC2C2_C2C2);
        expect_issue(t, 1'b0);
        finish_write(t);
        expect_issue(t, 1'b0);
        finish_write(t);
        expect_issue(t, 1'b0);
        req_valid = '0;
        finish_write(t);

        // Timeout, then success on the expiry cycle
        post_req(1, 1'b0, 32'h4000_0000, 32'h5555_AAAA);
        expect_issue(t, 1'b1);
        finish_read(t, CPL_TIMEOUT, 1'b0, 1'b0, 1'b0);
        post_req(1, 1'b0, 32'h4000_0004, 32'h6666_9999);
        expect_issue(t, 1'b1);
        finish_read(t, CPL_TIMEOUT, 1'b1, 1'b0, 1'b1);

        // Link drop while waiting for a completion
        post_req(0, 1'b0, 32'h5000_0000, 32'h7777_8888);
        expect_issue(t, 1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (2) tick();
        user_lnk_up = 1'b0;
        tick();
        exp_err = exp_err + 16'd1;
        chk("lnk_rsp_fail", 128'(rsp_fail),  128'(oh(0)));
        chk("lnk_rsp_ok",   128'(rsp_ok),    128'(0));
        chk("lnk_busy",     128'(busy),      128'(1'b0));
        chk("lnk_tx_start", 128'(tx_start),  128'(1'b0));
        chk("lnk_err",      128'(err_count), 128'(exp_err));
        post_req(1, 1'b1, 32'h5000_0004, 32'h9999_0000);
        repeat (3) begin
            tick();
            chk("lnk_no_ack",  128'(req_ack),  128'(0));
            chk("lnk_one_rsp", 128'(rsp_fail), 128'(0));
        end
        user_lnk_up = 1'b1;
        expect_issue(t, 1'b1);
        finish_write(t);

        // 256 issues so the tag passes FF -> 00
        for (int i = 0; i < 256; i++) begin
            post_req(2, 1'b1, 32'h6000_0000 + 32'(i * 4), 32'(i) ^ 32'h5A5A_0000);
            expect_issue(t, 1'b1);
            finish_write(t);
        end
        chk("tag_wrapped", 128'(exp_tag), 128'(8'd11));

        // Reset mid-transaction: no response, everything back to reset
        post_req(2, 1'b0, 32'h7000_0000, 32'h1111_2222);
        expect_issue(t, 1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        reset   = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset   = 1'b0;
        exp_tag = 8'h00;
        exp_err = 16'h0;
        tick();
        chk("midreset_no_rsp", 128'(rsp_ok | rsp_fail), 128'(0));
        post_req(0, 1'b1, 32'h8000_0000, 32'h3333_4444);
        expect_issue(t, 1'b1);
        finish_write(t);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
